// File: rtl/i2c_slave_mem.sv
// I2C write/read slave fronting a 16x8 register memory with an auto-incrementing pointer.
// The bus is oversampled on clk; SCL/SDA edges are recovered from 2-flop synchronized copies.
module i2c_slave_mem #(
    parameter logic [6:0] SLV_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic        pend_q, pend_d;
    logic        wr_valid_q, wr_valid_d;
    logic [7:0]  dout_q, dout_d;
    logic [3:0]  wr_addr_q, wr_addr_d;

    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  ptr_inc;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign ptr_inc   = ptr_q + 4'd1;

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign dout     = dout_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 4'd0;
            mem_q      <= '{default: 8'h00};
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            pend_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            dout_q     <= 8'h00;
            wr_addr_q  <= 4'd0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            mem_q      <= mem_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            pend_q     <= pend_d;
            wr_valid_q <= wr_valid_d;
            dout_q     <= dout_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        mem_d      = mem_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        pend_d     = pend_q;
        wr_valid_d = 1'b0;
        dout_d     = dout_q;
        wr_addr_d  = wr_addr_q;

        // START/STOP override everything, which also discards any partial byte.
        if (stop_det) begin
            state_d  = IDLE;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            pend_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = 4'd0;
            ptr_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_DATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        bitcnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == SLV_ADDR) begin
                                state_d  = ADDR_ACK;
                                busy_d   = 1'b1;
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d  = WAIT_STOP;
                            end
                        end else begin
                            mem_d[ptr_q] = shift_q;
                            dout_d       = shift_q;
                            wr_addr_d    = ptr_q;
                            wr_valid_d   = 1'b1;
                            ptr_d        = ptr_inc;
                            state_d      = WR_ACK;
                            sda_oe_d     = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = RD_DATA;
                            shift_d  = mem_q[ptr_q];
                            sda_oe_d = ~mem_q[ptr_q][7];
                        end else begin
                            state_d  = WR_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = WR_DATA;
                        sda_oe_d = 1'b0;
                    end
                end
                RD_DATA: begin
                    // pend_q: byte loaded at a rising edge, MSB goes out at the next falling edge.
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (pend_q) begin
                            sda_oe_d = ~shift_q[7];
                            pend_d   = 1'b0;
                        end else if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 4'd0;
                            state_d  = RD_ACK;
                        end else if (bitcnt_q != 4'd0) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_inc;
                            shift_d = mem_q[ptr_inc];
                            pend_d  = 1'b1;
                            state_d = RD_DATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
